// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, flag layout and shared helpers
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

  // Field order matches FLAG_Z/FLAG_N/FLAG_C bit positions.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
  } alu_flags_t;

  // Only the arithmetic ops produce a meaningful carry out.
  function automatic logic op_sets_carry(input logic [2:0] ctrl);
    return (ctrl == OP_ADD) || (ctrl == OP_SUB) || (ctrl == OP_INC);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational Z/N/C derivation from an ALU result
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] result,
  input  logic             cout,
  input  logic [2:0]       ctrl,
  output alu_flags_t       flags
);

  assign flags.z = (result == '0);
  assign flags.n = result[WIDTH-1];
  assign flags.c = cout & op_sets_carry(ctrl);

endmodule

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - FWFT result/flag FIFO with last-result feedback
// Optional push/carry statistics counters when ALU_RESULT_STATS_EN is defined.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_result,
  input  logic                    in_cout,
  input  logic [2:0]              in_ctrl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_result,
  output logic [2:0]              out_flags,
  output logic [2:0]              out_ctrl,
  output logic [WIDTH-1:0]        last_result,
  output logic [$clog2(DEPTH):0]  count
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [15:0]             stat_pushes,
  output logic [15:0]             stat_carries
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem_result [DEPTH];
  alu_flags_t       mem_flags  [DEPTH];
  logic [2:0]       mem_ctrl   [DEPTH];
  alu_flags_t       in_flags;
  logic             push;
  logic             pop;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result (in_result),
    .cout   (in_cout),
    .ctrl   (in_ctrl),
    .flags  (in_flags)
  );

  // Ready depends only on registered occupancy; a full buffer never accepts alongside a pop.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign out_result = out_valid ? mem_result[rd_ptr] : '0;
  assign out_flags  = out_valid ? mem_flags[rd_ptr]  : '0;
  assign out_ctrl   = out_valid ? mem_ctrl[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_result <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + AW'(1);
        last_result <= in_result;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= in_result;
      mem_flags[wr_ptr]  <= in_flags;
      mem_ctrl[wr_ptr]   <= in_ctrl;
    end
  end

`ifdef ALU_RESULT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pushes  <= '0;
      stat_carries <= '0;
    end else if (push) begin
      if (stat_pushes != 16'hFFFF) begin
        stat_pushes <= stat_pushes + 16'd1;
      end
      if (in_flags.c && (stat_carries != 16'hFFFF)) begin
        stat_carries <= stat_carries + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - scoreboard bench for alu_result_buffer
module tb_alu_result_buffer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic [2:0]       flags;
    logic [2:0]       ctrl;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_cout;
  logic [2:0]       in_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_flags;
  logic [2:0]       out_ctrl;
  logic [WIDTH-1:0] last_result;
  logic [2:0]       count;
`ifdef ALU_RESULT_STATS_EN
  logic [15:0]      stat_pushes;
  logic [15:0]      stat_carries;
  int               exp_pushes;
  int               exp_carries;
`endif

  int   checks;
  int   errors;
  exp_t q[$];

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_cout     (in_cout),
    .in_ctrl     (in_ctrl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .out_ctrl    (out_ctrl),
    .last_result (last_result),
    .count       (count)
`ifdef ALU_RESULT_STATS_EN
    ,
    .stat_pushes  (stat_pushes),
    .stat_carries (stat_carries)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] model_flags(input logic [WIDTH-1:0] r, input logic c,
                                             input logic [2:0] op);
    logic z, n, cf;
    z  = (r == 0);
    n  = r[WIDTH-1];
    cf = c && (op == 3'd0 || op == 3'd1 || op == 3'd2);
    return {z, n, cf};
  endfunction

  // Scoreboard monitor: handshakes are decided at the falling edge, ahead of the rising edge.
  always @(negedge clk) begin
    exp_t e;
    bit   room;
    if (rst_n) begin
      if (flush) begin
        q.delete();
      end else begin
        room = (q.size() != DEPTH);
        if (out_valid && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL pop_empty: dut out_valid=1 result=%0d but scoreboard is empty", out_result);
          end else begin
            e = q.pop_front();
            if ({out_result, out_flags, out_ctrl} !== {e.result, e.flags, e.ctrl}) begin
              errors++;
              $display("FAIL pop_data: got res=%0d flags=%b ctrl=%b, expected res=%0d flags=%b ctrl=%b",
                       out_result, out_flags, out_ctrl, e.result, e.flags, e.ctrl);
            end
          end
        end
        if (in_valid && room) begin
          e.result = in_result;
          e.flags  = model_flags(in_result, in_cout, in_ctrl);
          e.ctrl   = in_ctrl;
          q.push_back(e);
`ifdef ALU_RESULT_STATS_EN
          exp_pushes++;
          if (e.flags[0]) exp_carries++;
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] r, input logic c, input logic [2:0] op);
    in_valid  = v;
    in_result = r;
    in_cout   = c;
    in_ctrl   = op;
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({count, in_ready, out_valid} !== {3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: count=%0d in_ready=%b out_valid=%b, expected 0/1/0", count, in_ready, out_valid);
    end
    checks++;
    if ({out_result, out_flags, out_ctrl, last_result} !== 14'd0) begin
      errors++;
      $display("FAIL reset_data: res=%0d flags=%b ctrl=%b last=%0d, expected all 0",
               out_result, out_flags, out_ctrl, last_result);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_push();
    drive(1'b1, 4'd8, 1'b0, 3'b000);
    step();
    drive(1'b0, 4'd0, 1'b0, 3'b000);
    checks++;
    if ({out_valid, out_result, out_flags, count, last_result} !== {1'b1, 4'd8, 3'b010, 3'd1, 4'd8}) begin
      errors++;
      $display("FAIL first_push: valid=%b res=%0d flags=%b count=%0d last=%0d, expected 1/8/010/1/8",
               out_valid, out_result, out_flags, count, last_result);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL first_drain: count=%0d expected 0", count);
    end
  endtask

  task automatic test_flags();
    drive(1'b1, 4'd0, 1'b1, 3'b000);
    step();
    checks++;
    if (out_flags !== 3'b101) begin
      errors++;
      $display("FAIL flags_add: flags=%b expected 101", out_flags);
    end
    drive(1'b1, 4'd0, 1'b1, 3'b110);
    step();
    drive(1'b0, 4'd0, 1'b0, 3'b000);
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_flags, out_ctrl} !== {3'b100, 3'b110}) begin
      errors++;
      $display("FAIL flags_xor: flags=%b ctrl=%b expected 100/110", out_flags, out_ctrl);
    end
    step();
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL flags_drain: count=%0d expected 0", count);
    end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0, 3'b011);
      step();
    end
    checks++;
    if ({count, in_ready} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL full_state: count=%0d in_ready=%b expected 4/0", count, in_ready);
    end
    drive(1'b1, 4'd5, 1'b0, 3'b011);
    step();
    drive(1'b0, 4'd0, 1'b0, 3'b000);
    checks++;
    if ({count, last_result} !== {3'd4, 4'd4}) begin
      errors++;
      $display("FAIL full_ignore: count=%0d last=%0d expected 4/4", count, last_result);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    checks++;
    if ({count, out_valid, q.size() == 0} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL full_drain: count=%0d out_valid=%b left=%0d expected 0/0/0", count, out_valid, q.size());
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd10, 1'b1, 3'b001);
    step();
    drive(1'b1, 4'd11, 1'b0, 3'b100);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, WIDTH'(12 + i), 1'(i), 3'(i));
      step();
      checks++;
      if (count !== 3'd2) begin
        errors++;
        $display("FAIL b2b_count: cycle %0d count=%0d expected 2", i, count);
      end
    end
    drive(1'b0, 4'd0, 1'b0, 3'b000);
    step();
    step();
    out_ready = 1'b0;
    checks++;
    if ({count, last_result} !== {3'd0, 4'd1}) begin
      errors++;
      $display("FAIL b2b_end: count=%0d last=%0d expected 0/1", count, last_result);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WIDTH'(7 + i), 1'b0, 3'b101);
      step();
    end
    drive(1'b1, 4'd5, 1'b1, 3'b000);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 3'b000);
    checks++;
    if ({count, out_valid, in_ready, last_result, out_result} !== {3'd0, 1'b0, 1'b1, 4'd9, 4'd0}) begin
      errors++;
      $display("FAIL flush: count=%0d valid=%b ready=%b last=%0d res=%0d expected 0/0/1/9/0",
               count, out_valid, in_ready, last_result, out_result);
    end
    drive(1'b1, 4'd3, 1'b1, 3'b010);
    step();
    drive(1'b0, 4'd0, 1'b0, 3'b000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL flush_after: count=%0d expected 0", count);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'd6, 1'b1, 3'b001);
    step();
    drive(1'b1, 4'd14, 1'b0, 3'b111);
    step();
    drive(1'b0, 4'd0, 1'b0, 3'b000);
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL areset_pre: count=%0d expected 2", count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, count, in_ready, last_result, out_result} !== {1'b0, 3'd0, 1'b1, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL areset: valid=%b count=%0d ready=%b last=%0d res=%0d expected 0/0/1/0/0",
               out_valid, count, in_ready, last_result, out_result);
    end
`ifdef ALU_RESULT_STATS_EN
    checks++;
    if ({stat_pushes, stat_carries} !== 32'd0) begin
      errors++;
      $display("FAIL areset_stats: pushes=%0d carries=%0d expected 0/0", stat_pushes, stat_carries);
    end
    exp_pushes  = 0;
    exp_carries = 0;
`endif
    q.delete();
    rst_n = 1'b1;
    step();
    drive(1'b1, 4'd2, 1'b1, 3'b000);
    step();
    drive(1'b0, 4'd0, 1'b0, 3'b000);
    checks++;
    if ({count, out_result, out_flags} !== {3'd1, 4'd2, 3'b001}) begin
      errors++;
      $display("FAIL areset_after: count=%0d res=%0d flags=%b expected 1/2/001", count, out_result, out_flags);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 3'b000);
`ifdef ALU_RESULT_STATS_EN
    exp_pushes  = 0;
    exp_carries = 0;
`endif
    test_reset();
    test_first_push();
    test_flags();
    test_full();
    test_back_to_back();
    test_flush();
`ifdef ALU_RESULT_STATS_EN
    checks++;
    if ({stat_pushes, stat_carries} !== {exp_pushes[15:0], exp_carries[15:0]}) begin
      errors++;
      $display("FAIL stats: pushes=%0d carries=%0d expected %0d/%0d",
               stat_pushes, stat_carries, exp_pushes, exp_carries);
    end
`endif
    test_async_reset();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d scoreboard entries never popped, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
